// File: rtl/alu_issue_if.sv
// Command/response handshake bundle between a sequencer client and
// alu_issue_ctrl.
interface alu_issue_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_rd;
  logic [2:0]       cmd_rs1;
  logic [2:0]       cmd_rs2;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;
  logic [SHW-1:0]   cmd_shamt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_rd,
    output cmd_rs1, cmd_rs2,
    output cmd_imm_en, cmd_imm, cmd_shamt,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_flags,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd,
    input  cmd_rs1, cmd_rs2,
    input  cmd_imm_en, cmd_imm, cmd_shamt,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_flags,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the combinational ALU: local regfile,
// iterated single-bit shifts, writeback and flagged response.
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_if.slave       bus,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] regs [8];
  logic [2:0]       op;
  logic [2:0]       rd;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cmd_fire;
  logic             is_shift;
  logic             wb;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic             neg;
  logic             zero;

  assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
  assign is_shift = (bus.cmd_op == OP_SHR) ||
                    (bus.cmd_op == OP_SHL);

  // R0 is never written, but the read mux keeps it zero regardless
  assign rs1_val = (bus.cmd_rs1 == 3'd0) ? '0 : regs[bus.cmd_rs1];
  assign rs2_val = (bus.cmd_rs2 == 3'd0) ? '0 : regs[bus.cmd_rs2];

  assign neg  = wb_data[WIDTH-1];
  assign zero = (wb_data == '0);

  always_comb begin
    state_n       = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_in0       = '0;
    alu_in1       = '0;
    alu_sel       = 3'b000;
    wb            = 1'b0;
    wb_data       = alu_out;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid)
          state_n = is_shift ? SHIFT : EXEC;
      end
      EXEC: begin
        alu_in0 = opa;
        alu_in1 = opb;
        alu_sel = op;
        wb      = 1'b1;
        state_n = RESP;
      end
      SHIFT: begin
        // opa doubles as the shift accumulator
        alu_in0 = opa;
        alu_in1 = opb;
        alu_sel = op;
        if (cnt == '0) begin
          wb      = 1'b1;
          wb_data = opa;
          state_n = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op            <= '0;
      rd            <= '0;
      cnt           <= '0;
      opa           <= '0;
      opb           <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_flags <= '0;
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else begin
      state <= state_n;
      if (cmd_fire) begin
        op  <= bus.cmd_op;
        rd  <= bus.cmd_rd;
        cnt <= bus.cmd_shamt;
        opa <= rs1_val;
        opb <= bus.cmd_imm_en ? bus.cmd_imm : rs2_val;
      end
      if (state == SHIFT && cnt != '0) begin
        opa <= alu_out;
        cnt <= cnt - 1'b1;
      end
      if (wb) begin
        bus.rsp_data  <= wb_data;
        bus.rsp_flags <= {neg, !neg && !zero, zero};
        if (rd != 3'd0)
          regs[rd] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural single-bit ALU
// attached to the issue stage's ALU port.
module tb_alu_issue_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_in0;
  logic [WIDTH-1:0] alu_in1;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;

  int n_chk;
  int n_fail;

  alu_issue_if #(.WIDTH(WIDTH)) bus ();

  alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .alu_in0 (alu_in0),
    .alu_in1 (alu_in1),
    .alu_sel (alu_sel),
    .alu_out (alu_out)
  );

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'b000: alu_out = alu_in0 + alu_in1;
      3'b001: alu_out = alu_in0 - alu_in1;
      3'b010: alu_out = alu_in0 >> 1;
      3'b011: alu_out = alu_in0 << 1;
      3'b100: alu_out = alu_in0 & alu_in1;
      3'b101: alu_out = alu_in0 | alu_in1;
      3'b110: alu_out = alu_in0 ^ alu_in1;
      default: alu_out = ~alu_in0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [2:0] rd,
                       input logic [2:0] rs1,
                       input logic [2:0] rs2,
                       input logic       imm_en,
                       input logic [31:0] imm,
                       input logic [4:0] shamt);
    chk("cmd_ready_pre", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_rd     = rd;
    bus.cmd_rs1    = rs1;
    bus.cmd_rs2    = rs2;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_shamt  = shamt;
    step();
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [2:0] rd,
                     input logic [2:0] rs1,
                     input logic [2:0] rs2,
                     input logic       imm_en,
                     input logic [31:0] imm,
                     input logic [4:0] shamt,
                     input logic [31:0] exp,
                     input logic [2:0] flags,
                     input int         lat);
    int n;
    issue(op, rd, rs1, rs2, imm_en, imm, shamt);
    chk({tag, "_sel"}, alu_sel, op);
    n = 1;
    while (!bus.rsp_valid && n < 100) begin
      chk({tag, "_busy"}, bus.cmd_ready, 0);
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, bus.rsp_data, exp);
    chk({tag, "_flags"}, bus.rsp_flags, flags);
    chk({tag, "_alu_idle"}, {alu_sel, alu_in0}, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, bus.cmd_ready, 1);
    chk({tag, "_valid_after"}, bus.rsp_valid, 0);
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = '0;
    bus.cmd_shamt  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_flags", bus.rsp_flags, 0);
    chk("rst_alu", {alu_sel, alu_in1, alu_in0}, 0);

    run("add_imm", 3'b000, 3'd1, 3'd0, 3'd0, 1, 32'd5, 0,
        32'd5, 3'b010, 2);
    run("rd_r1", 3'b000, 3'd2, 3'd1, 3'd0, 1, 32'd0, 0,
        32'd5, 3'b010, 2);
    run("sub", 3'b001, 3'd2, 3'd1, 3'd0, 1, 32'd7, 0,
        32'hFFFF_FFFE, 3'b100, 2);
    run("xor", 3'b110, 3'd3, 3'd2, 3'd2, 0, 32'd0, 0,
        32'd0, 3'b001, 2);
    run("shl4", 3'b011, 3'd4, 3'd1, 3'd0, 1, 32'd0, 5'd4,
        32'h50, 3'b010, 6);
    run("shr0", 3'b010, 3'd5, 3'd1, 3'd0, 1, 32'd0, 5'd0,
        32'd5, 3'b010, 2);
    run("ld_msb", 3'b000, 3'd6, 3'd0, 3'd0, 1, 32'h8000_0000, 0,
        32'h8000_0000, 3'b100, 2);
    run("shr31", 3'b010, 3'd6, 3'd6, 3'd0, 1, 32'd0, 5'd31,
        32'd1, 3'b010, 33);
    run("and", 3'b100, 3'd7, 3'd4, 3'd2, 0, 32'd0, 0,
        32'h50, 3'b010, 2);
    run("or", 3'b101, 3'd7, 3'd4, 3'd3, 0, 32'd0, 0,
        32'h50, 3'b010, 2);
    run("not", 3'b111, 3'd7, 3'd4, 3'd0, 1, 32'h1234, 0,
        32'hFFFF_FFAF, 3'b100, 2);
    run("wr_r0", 3'b000, 3'd0, 3'd0, 3'd0, 1, 32'd9, 0,
        32'd9, 3'b010, 2);
    run("rd_r0", 3'b000, 3'd1, 3'd0, 3'd0, 0, 32'd0, 0,
        32'd0, 3'b001, 2);
    run("rd_r7", 3'b000, 3'd1, 3'd7, 3'd0, 1, 32'd0, 0,
        32'hFFFF_FFAF, 3'b100, 2);

    // backpressure: response must hold, no new command taken
    issue(3'b000, 3'd1, 3'd4, 3'd0, 1, 32'd1, 0);
    step();
    chk("bp_valid0", bus.rsp_valid, 1);
    bus.cmd_op     = 3'b000;
    bus.cmd_rd     = 3'd2;
    bus.cmd_rs1    = 3'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 32'd99;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = ~bus.cmd_valid;
      step();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 32'h51);
      chk("bp_flags", bus.rsp_flags, 3'b010);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_ready_after", bus.cmd_ready, 1);
    run("bp_r2", 3'b000, 3'd3, 3'd2, 3'd0, 1, 32'd0, 0,
        32'hFFFF_FFFE, 3'b100, 2);
    run("bp_r1", 3'b000, 3'd3, 3'd1, 3'd0, 1, 32'd0, 0,
        32'h51, 3'b010, 2);

    // reset in the middle of a long shift
    issue(3'b011, 3'd5, 3'd1, 3'd0, 1, 32'd0, 5'd20);
    for (int i = 0; i < 4; i++) begin
      chk("mid_valid", bus.rsp_valid, 0);
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_valid", bus.rsp_valid, 0);
    step();
    rst = 1'b0;
    chk("mid_ready", bus.cmd_ready, 1);
    chk("mid_data", bus.rsp_data, 0);
    for (int i = 0; i < 25; i++) begin
      chk("mid_quiet", bus.rsp_valid, 0);
      step();
    end
    run("mid_r5", 3'b000, 3'd1, 3'd5, 3'd0, 1, 32'd0, 0,
        32'd0, 3'b001, 2);
    run("mid_r1", 3'b000, 3'd2, 3'd1, 3'd0, 1, 32'd0, 0,
        32'd0, 3'b001, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/sequencing stage directly upstream of the combinational `alu`. It accepts register-to-register or register-immediate commands over a valid/ready handshake and reads operands from a local 8-entry register file. It drives the ALU's `in0`/`in1`/`sel` inputs, writes the result back, and returns result plus neg/pos/zero flags over a second valid/ready handshake. Multi-bit shifts are built by iterating the ALU's single-bit `SHR`/`SHL` operation.

## Interface
- `WIDTH`, 32, datapath width; must match the connected `alu`.
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived; not overridden).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  ALU op code: ADD=000, SUB=001, SHR=010, SHL=011, AND=100, OR=101, XOR=110, NOT=111.
- `cmd_rd`  in  3  destination register; R0 is hardwired zero.
- `cmd_rs1`  in  3  source A register.
- `cmd_rs2`  in  3  source B register.
- `cmd_imm_en`  in  1  1: operand B = `cmd_imm`; 0: operand B = R[rs2].
- `cmd_imm`  in  WIDTH  immediate.
- `cmd_shamt`  in  SHW  shift count for SHR/SHL; ignored otherwise.
- `alu_in0`  out  WIDTH  to ALU `in0`.
- `alu_in1`  out  WIDTH  to ALU `in1`.
- `alu_sel`  out  3  to ALU `sel`.
- `alu_out`  in  WIDTH  from ALU `out`.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  WIDTH  result.
- `rsp_flags`  out  3  {neg, pos, zero} of `rsp_data`.

## Operation
- Register file: R0..R7, WIDTH bits each.
  - R0 always reads 0; writes to it are discarded.
- FSM states: IDLE, EXEC, SHIFT, RESP.
- IDLE:
  - `cmd_ready=1`.
  - On handshake, latch `op`, `rd`, `shamt`, `opA=R[rs1]`, and `opB = cmd_imm_en ? cmd_imm : R[rs2]`.
  - SHR/SHL go to SHIFT with `acc=opA` and `cnt=shamt`. All other ops go to EXEC.
- EXEC:
  - Drive `alu_in0=opA`, `alu_in1=opB`, `alu_sel=op`.
  - Capture `result=alu_out`, then go to RESP.
  - NOT ignores `opB`.
- SHIFT:
  - Drive `alu_in0=acc`, `alu_in1=opB`, `alu_sel=op`.
  - If `cnt!=0`: `acc<=alu_out` and `cnt<=cnt-1`; stay in SHIFT.
  - If `cnt==0`: `result=acc`, then go to RESP.
  - `shamt=0` therefore returns `opA` unchanged.
- Writeback: on the edge entering RESP, `R[rd]<=result` (unless `rd==0`), `rsp_data<=result`, and `rsp_flags<=` flags.
- Flags are computed locally from `result` (signed interpretation):
  - neg = `result[WIDTH-1]`
  - zero = `(result==0)`
  - pos = `!neg && !zero`
  - Exactly one flag is set.
- RESP:
  - `rsp_valid=1`; `rsp_data` and `rsp_flags` are held stable.
  - On `rsp_ready`, go to IDLE.
- `cmd_ready=0` in EXEC, SHIFT and RESP. `cmd_valid` is ignored in those states.
- In IDLE and RESP, `alu_in0=0`, `alu_in1=0`, `alu_sel=000`.
- Arithmetic is modulo 2^WIDTH; no overflow or carry reporting.
- Reset values:
  - state IDLE; R1..R7 = 0.
  - `cmd_ready=1`.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_flags=000`.
  - `alu_in0=0`, `alu_in1=0`, `alu_sel=000`.
- Reset mid-operation: the in-flight command is discarded with no writeback and no response. A pending RESP is dropped.

## Timing
- Command handshake at edge T.
- Non-shift ops: EXEC during cycle T+1; `rsp_valid` high from T+2.
- Shift with count N: SHIFT during T+1..T+N+1; `rsp_valid` high from T+N+2.
- Register write and `rsp_valid` rise on the same edge. A command accepted after the response handshake sees the updated register, so there are no hazards.
- Response handshake at edge R: `cmd_ready=1` in cycle R+1.
- Back-to-back non-shift throughput: one command per 3 cycles with `rsp_ready` tied high.
- `rsp_valid` stays high, with `rsp_data` unchanged, until `rsp_ready` is sampled high.

## Test plan
- Reset, then ADD rd=1, rs1=0, imm=5: `rsp_data=5` and `rsp_flags=010` at T+2; a later read of R1 via ADD rd=2, rs1=1, imm=0 returns 5.
- SUB rd=2, rs1=1 (5), imm=7: `rsp_data=0xFFFFFFFE`, `rsp_flags=100`. Then XOR rd=3, rs1=2, rs2=2: `rsp_data=0`, `rsp_flags=001`.
- SHL rd=4, rs1=1 (5), shamt=4: `rsp_data=0x50` at T+6. SHR with shamt=0: `rsp_data=5` at T+2. SHR of 0x80000000 with shamt=31: `rsp_data=1`.
- ADD rd=0, imm=9: `rsp_data=9` reported. A subsequent ADD rd=1, rs1=0, imm=0 returns 0.
- Backpressure: hold `rsp_ready=0` for 5 cycles while toggling `cmd_valid`. `rsp_data` and `rsp_flags` stay stable, `cmd_ready` stays 0, and no extra command is accepted.
- Issue SHL, shamt=20, rd=5, then assert `rst` 5 cycles later. No `rsp_valid` is produced, R5 reads 0 afterwards, and `cmd_ready=1` in the first cycle after `rst` deasserts.
